// File: rtl/pad_scan_pkg.sv
// pad_scan_pkg: shared types and constants for the Genesis pad scan sequencer.
//   scan_state_e  - select sequencing states
//   BTN_*         - bit positions inside the 11-bit button frame
//   NUM_BUTTONS   - frame width
// Optional feature macro used by the block: PAD_SCAN_REPEAT_EN (auto-repeat).
package pad_scan_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEL_LOW  = 2'd1,
    SEL_HIGH = 2'd2
  } scan_state_e;

  localparam int unsigned NUM_BUTTONS = 11;
  localparam int unsigned PHASE_W     = 8;
  localparam int unsigned HOLD_W      = 8;

  // Button frame bit map
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_START = 5;
  localparam int unsigned BTN_Z     = 6;
  localparam int unsigned BTN_Y     = 7;
  localparam int unsigned BTN_X     = 8;
  localparam int unsigned BTN_B     = 9;
  localparam int unsigned BTN_C     = 10;

  typedef logic [NUM_BUTTONS-1:0] btn_frame_t;

  // Bits captured while select is low; the rest are captured while select is high
  localparam btn_frame_t LO_PHASE_MASK = btn_frame_t'(11'h03F);

endpackage

// File: rtl/pad_repeat_gen.sv
// pad_repeat_gen: hold counter and auto-repeat decision for published frames.
//   clk, reset       - clock, synchronous active-low reset
//   frame_stb        - a frame is being published this cycle
//   level_new        - frame being published
//   level_old        - previously published frame
//   repeat_c         - combinational: this frame's press output must repeat the level
// Only instantiated when PAD_SCAN_REPEAT_EN is defined.
module pad_repeat_gen
  import pad_scan_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 30,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_stb,
  input  btn_frame_t level_new,
  input  btn_frame_t level_old,
  output logic       repeat_c
);

  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [HOLD_W-1:0] hold_inc_c;

  // Hold counter advances once per published frame of an unchanged nonzero level
  always_comb begin
    hold_d     = hold_q;
    repeat_c   = 1'b0;
    hold_inc_c = hold_q + HOLD_W'(1);
    if (frame_stb) begin
      if ((level_new != level_old) || (level_new == '0)) begin
        hold_d = '0;
      end else if (hold_inc_c == HOLD_FIRE) begin
        repeat_c = 1'b1;
        hold_d   = HOLD_RELOAD;
      end else begin
        hold_d = hold_inc_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/pad_scan_sequencer.sv
// pad_scan_sequencer: select-line scan controller for a 3-button-group Genesis pad.
// Every SCAN_PERIOD cycles (when enabled and idle) it drives select low then high
// for SETTLE_CYCLES each, samples the six pad pins on the last cycle of each phase
// and publishes one 11-bit frame with level and new-press views.
//   clk, reset                  - clock, synchronous active-low reset
//   enable                      - permits new scans (a running scan always completes)
//   up_z..start_c               - conditioned pad pins, 1 = pressed
//   select_out                  - pad select line
//   buttons_level               - last published frame
//   buttons_press               - press pulses, valid with frame_valid
//   frame_valid                 - one-cycle strobe per published frame
// Optional: PAD_SCAN_REPEAT_EN adds auto-repeat (REPEAT_DELAY / REPEAT_RATE).
module pad_scan_sequencer
  import pad_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SCAN_PERIOD   = 50000
`ifdef PAD_SCAN_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 30,
  parameter int unsigned REPEAT_RATE   = 6
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   up_z,
  input  logic                   down_y,
  input  logic                   left_x,
  input  logic                   right,
  input  logic                   a_b,
  input  logic                   start_c,
  output logic                   select_out,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] buttons_press,
  output logic                   frame_valid
);

  localparam int unsigned PERIOD_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 2;
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SCAN_PERIOD - 1);
  localparam logic [PHASE_W-1:0]  PHASE_LAST  = PHASE_W'(SETTLE_CYCLES - 1);

  scan_state_e         state_q,  state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PHASE_W-1:0]  phase_q,  phase_d;
  btn_frame_t          shadow_q, shadow_d;
  btn_frame_t          level_q,  level_d;
  btn_frame_t          press_q,  press_d;
  logic                fv_q,     fv_d;
  logic                select_q, select_d;

  logic       tick_c;
  logic       phase_done_c;
  logic       publish_c;
  logic       repeat_c;
  btn_frame_t lo_pins_c;
  btn_frame_t hi_pins_c;
  btn_frame_t frame_c;

  // Pin-to-frame mapping for each select phase; right has no meaning while select is high
  always_comb begin
    lo_pins_c            = '0;
    lo_pins_c[BTN_UP]    = up_z;
    lo_pins_c[BTN_DOWN]  = down_y;
    lo_pins_c[BTN_LEFT]  = left_x;
    lo_pins_c[BTN_RIGHT] = right;
    lo_pins_c[BTN_A]     = a_b;
    lo_pins_c[BTN_START] = start_c;
    hi_pins_c            = '0;
    hi_pins_c[BTN_Z]     = up_z;
    hi_pins_c[BTN_Y]     = down_y;
    hi_pins_c[BTN_X]     = left_x;
    hi_pins_c[BTN_B]     = a_b;
    hi_pins_c[BTN_C]     = start_c;
  end

  assign tick_c       = (period_q == PERIOD_LAST);
  assign phase_done_c = (phase_q == PHASE_LAST);
  assign publish_c    = (state_q == SEL_HIGH) && phase_done_c;

  // High-phase pins are captured on the same edge that publishes, so the
  // published frame combines the stored low half with the live high half.
  assign frame_c = (shadow_q & LO_PHASE_MASK) | hi_pins_c;

`ifdef PAD_SCAN_REPEAT_EN
  pad_repeat_gen #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat (
    .clk       (clk),
    .reset     (reset),
    .frame_stb (publish_c),
    .level_new (frame_c),
    .level_old (level_q),
    .repeat_c  (repeat_c)
  );
`else
  assign repeat_c = 1'b0;
`endif

  // Next-state, counters, capture and publish
  always_comb begin
    state_d  = state_q;
    period_d = tick_c ? '0 : (period_q + PERIOD_W'(1));
    phase_d  = phase_q;
    shadow_d = shadow_q;
    level_d  = level_q;
    press_d  = '0;
    fv_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_c && enable) begin
          state_d = SEL_LOW;
          phase_d = '0;
        end
      end
      SEL_LOW: begin
        if (phase_done_c) begin
          shadow_d = (shadow_q & ~LO_PHASE_MASK) | lo_pins_c;
          state_d  = SEL_HIGH;
          phase_d  = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      SEL_HIGH: begin
        if (phase_done_c) begin
          shadow_d = frame_c;
          state_d  = IDLE;
          phase_d  = '0;
          level_d  = frame_c;
          press_d  = (frame_c & ~level_q) | (repeat_c ? frame_c : '0);
          fv_d     = 1'b1;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Select is registered from the next state so it tracks the phase exactly
    select_d = (state_d != SEL_LOW);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      phase_q  <= '0;
      shadow_q <= '0;
      level_q  <= '0;
      press_q  <= '0;
      fv_q     <= 1'b0;
      select_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      level_q  <= level_d;
      press_q  <= press_d;
      fv_q     <= fv_d;
      select_q <= select_d;
    end
  end

  assign select_out    = select_q;
  assign buttons_level = level_q;
  assign buttons_press = press_q;
  assign frame_valid   = fv_q;

endmodule

// File: doc/pad_scan_sequencer.md
# pad_scan_sequencer

Scan controller for the 3-pin-group Genesis pad. It drives the pad's select line through a fixed low/high sequence, waits a settle time in each phase, and samples the six multiplexed pad pins. It then publishes one coherent 11-bit button frame per scan period, with level and new-press views. It sits between the DB-9 pins and the top-level game logic, and replaces free-running select handling.

## Interface
- SETTLE_CYCLES, 4: cycles select is held in each phase before sampling; range 2..255.
- SCAN_PERIOD, 50000: cycles between scan starts; must exceed 2*SETTLE_CYCLES+2.
- REPEAT_DELAY, 30: frames a nonzero level must be held before the first auto-repeat; only used with the Configuration macro; range 2..255.
- REPEAT_RATE, 6: frames between subsequent auto-repeats; only used with the Configuration macro; range 1..REPEAT_DELAY.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  permits new scans
- up_z, down_y, left_x, right, a_b, start_c  in  1 each  conditioned pad pins, 1 = pressed
- select_out  out  1  pad select line
- buttons_level  out  11  last published frame; bit map: 0 up, 1 down, 2 left, 3 right, 4 A, 5 start, 6 Z, 7 Y, 8 X, 9 B, 10 C
- buttons_press  out  11  one-cycle press pulses, valid only with frame_valid
- frame_valid  out  1  one-cycle strobe, new frame published

## Operation
- Period counter runs 0..SCAN_PERIOD-1 and wraps. The scan tick is asserted when count == SCAN_PERIOD-1.
- A tick starts a scan only if enable=1 and the state is IDLE. Otherwise the tick is dropped; no queuing.
- FSM states:
  - IDLE: select_out=1.
  - SEL_LOW: select_out=0, lasts SETTLE_CYCLES cycles. On its last cycle, capture up_z, down_y, left_x, right, a_b, start_c into shadow[5:0].
  - SEL_HIGH: select_out=1, lasts SETTLE_CYCLES cycles. On its last cycle, capture up_z, down_y, left_x, a_b, start_c into shadow[10:6]. The right pin is ignored in this phase.
- Transitions: IDLE→SEL_LOW on tick, then SEL_LOW→SEL_HIGH, then SEL_HIGH→IDLE.
- Publish happens on the edge leaving SEL_HIGH:
  - buttons_level <= shadow
  - buttons_press <= shadow & ~buttons_level (old value)
  - frame_valid <= 1
- buttons_press and frame_valid return to 0 on the following cycle.
- enable dropped mid-scan: the current scan completes and publishes; no new scan starts.
- Reset at any time: state IDLE, all counters 0, shadow 0, select_out=1, buttons_level/buttons_press/frame_valid = 0. A scan in progress is abandoned with no publish.

## Timing
- All outputs are registered.
- Take cycle 0 as the first cycle with reset=1. The tick occurs at cycle SCAN_PERIOD-1 and SEL_LOW begins at cycle SCAN_PERIOD.
- Scan length is 2*SETTLE_CYCLES cycles. frame_valid goes high at cycle SCAN_PERIOD+2*SETTLE_CYCLES, then every SCAN_PERIOD cycles while enable=1.
- Pin changes during a settle window affect the frame only if present on that phase's sampling cycle.

## Configuration
- PAD_SCAN_REPEAT_EN defined: adds auto-repeat using a hold counter, 8 bits.
  - On a frame where the level changed or is zero, the counter clears.
  - Otherwise it increments.
  - When it reaches REPEAT_DELAY: buttons_press <= buttons_level for that frame, and the counter reloads with REPEAT_DELAY-REPEAT_RATE.
- PAD_SCAN_REPEAT_EN undefined: buttons_press is edge-only. No hold counter is instantiated, and the REPEAT_* parameters are unused.

## Structure
- Package pad_scan_pkg holds:
  - the state enum (IDLE, SEL_LOW, SEL_HIGH);
  - button bit-index constants BTN_UP..BTN_C;
  - NUM_BUTTONS = 11.
- Sub-module pad_repeat_gen holds the hold counter and repeat decision. It is instantiated only under PAD_SCAN_REPEAT_EN.

## Test plan
All scenarios use SETTLE_CYCLES=4 and SCAN_PERIOD=20.
- Reset release, enable=1, all pins 0 → select_out=1 at cycles 0..19, 0 at 20..23, 1 at 24..27; frame_valid at cycles 28, 48, 68; level=0, press=0.
- up_z held 1 throughout → frame at cycle 28: level=11'h041, press=11'h041; frame at cycle 48: level=11'h041, press=0.
- a_b=1 only while select_out=0 → level=11'h010; a_b=1 only while select_out=1 → level=11'h200.
- enable=0 from reset, raised at cycle 30 → first frame_valid at cycle 48; enable dropped at cycle 50 → no frame after 48.
- reset=0 at cycle 22, reset=1 from cycle 23 → select_out=1 at cycle 23, no frame_valid at cycle 28; the restarted period yields the first frame at cycle 51.
- PAD_SCAN_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2, right held → press=11'h008 on frames 1, 4, 6, 8; press=0 on frames 2, 3, 5, 7.
